// File: rtl/abs_diff_pkg.sv
// Shared definitions for the absolute-difference datapath: default operand
// width and the operand type used by the top and by the testbench.
package abs_diff_pkg;

  localparam int ABS_DIFF_WIDTH = 8;

  typedef logic [ABS_DIFF_WIDTH-1:0] operand_t;

endpackage : abs_diff_pkg

// File: rtl/abs_diff_sub.sv
// Ripple-borrow subtractor built from a chain of full subtractors.
// Produces diff = a - b (modulo 2^WIDTH) and the final borrow, which is
// set exactly when a < b for unsigned operands.
module abs_diff_sub
  import abs_diff_pkg::*;
#(
  parameter int WIDTH = ABS_DIFF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // chain[i] is the borrow into bit i; nothing is borrowed into bit 0
  logic [WIDTH:0] chain;

  assign chain[0] = 1'b0;

  // One full subtractor per bit, borrow rippling from LSB to MSB
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign diff[i]      = a[i] ^ b[i] ^ chain[i];
    assign chain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
  end

  assign borrow = chain[WIDTH];

endmodule : abs_diff_sub

// File: rtl/abs_diff.sv
// Registered unsigned absolute difference |data - Ref| with a less-than flag.
// One cycle of latency, full throughput, outputs hold while in_valid is low.
module abs_diff
  import abs_diff_pkg::*;
#(
  parameter int WIDTH = ABS_DIFF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] Ref,
  output logic [WIDTH-1:0] result,
  output logic             data_lt_ref,
  output logic             out_valid
);

  logic [WIDTH-1:0] raw_diff;
  logic             borrow;
  logic [WIDTH-1:0] flipped;
  logic [WIDTH-1:0] abs_val;

  abs_diff_sub #(
    .WIDTH (WIDTH)
  ) u_sub (
    .a      (data),
    .b      (Ref),
    .diff   (raw_diff),
    .borrow (borrow)
  );

  // When data < Ref the raw difference is negative in two's complement, so
  // invert and add one; with no borrow both steps collapse to a pass-through.
  // The magnitude always fits in WIDTH bits, so the increment cannot overflow.
  assign flipped = raw_diff ^ {WIDTH{borrow}};
  assign abs_val = flipped + {{(WIDTH-1){1'b0}}, borrow};

  // Output registers: reset wins, otherwise capture only on a valid input so
  // an idle (possibly undriven) bus never disturbs the held result
  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= '0;
      data_lt_ref <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result      <= abs_val;
        data_lt_ref <= borrow;
      end
    end
  end

endmodule : abs_diff

// File: tb/tb_abs_diff.sv
// Directed and randomized checks for abs_diff at the default 8-bit width.
module tb_abs_diff;
  import abs_diff_pkg::*;

  logic     clk;
  logic     rst;
  logic     in_valid;
  operand_t data;
  operand_t Ref;
  operand_t result;
  logic     data_lt_ref;
  logic     out_valid;

  int checkCount = 0;
  int passCount  = 0;

  abs_diff #(
    .WIDTH (ABS_DIFF_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .data        (data),
    .Ref         (Ref),
    .result      (result),
    .data_lt_ref (data_lt_ref),
    .out_valid   (out_valid)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs on the falling edge, then let one rising edge capture them
  // and settle just after it so outputs are sampled away from the edge
  task automatic applyStimulus(input logic r, input logic v,
                               input operand_t d, input operand_t b);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    data     = d;
    Ref      = b;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point; every check is counted here
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Check all three outputs against hand-computed values
  task automatic checkAll(input string tag, input int expResult,
                          input int expFlag, input int expValid);
    checkOutput({tag, ".result"},      int'(result),      expResult);
    checkOutput({tag, ".data_lt_ref"}, int'(data_lt_ref), expFlag);
    checkOutput({tag, ".out_valid"},   int'(out_valid),   expValid);
  endtask

  initial begin
    operand_t a;
    operand_t b;
    int       expAbs;

    rst      = 1'b1;
    in_valid = 1'b0;
    data     = '0;
    Ref      = '0;

    // Reset for two cycles
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h12, 8'h34);
    checkAll("reset", 0, 0, 0);

    // Basic and small deltas, back-to-back valid cycles
    applyStimulus(1'b0, 1'b1, 8'h2E, 8'h0E);
    checkAll("basic", 8'h20, 0, 1);
    applyStimulus(1'b0, 1'b1, 8'h2E, 8'h0F);
    checkAll("delta_borrow", 8'h1F, 0, 1);
    applyStimulus(1'b0, 1'b1, 8'h2F, 8'h0F);
    checkAll("delta_even", 8'h20, 0, 1);

    // data < Ref and its swap
    applyStimulus(1'b0, 1'b1, 8'h2F, 8'h8F);
    checkAll("lt", 8'h60, 1, 1);
    applyStimulus(1'b0, 1'b1, 8'h8F, 8'h2F);
    checkAll("lt_swapped", 8'h60, 0, 1);

    // Boundaries
    applyStimulus(1'b0, 1'b1, 8'h00, 8'hFF);
    checkAll("zero_vs_max", 8'hFF, 1, 1);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00);
    checkAll("max_vs_zero", 8'hFF, 0, 1);
    applyStimulus(1'b0, 1'b1, 8'hA5, 8'hA5);
    checkAll("equal", 8'h00, 0, 1);
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h00);
    checkAll("one_above", 8'h01, 0, 1);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h01);
    checkAll("one_below", 8'h01, 1, 1);

    // Idle with random operands: result and flag hold, out_valid drops
    applyStimulus(1'b0, 1'b0, 8'h3C, 8'hC3);
    checkAll("idle0", 8'h01, 1, 0);
    applyStimulus(1'b0, 1'b0, operand_t'($urandom), operand_t'($urandom));
    checkAll("idle1", 8'h01, 1, 0);

    // Reload, then reset while a valid input is presented
    applyStimulus(1'b0, 1'b1, 8'h10, 8'h90);
    checkAll("preload", 8'h80, 1, 1);
    applyStimulus(1'b1, 1'b1, 8'h77, 8'h11);
    checkAll("mid_reset", 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 8'h50, 8'h20);
    checkAll("post_reset", 8'h30, 0, 1);

    // Randomized against |a - b|
    for (int i = 0; i < 1000; i++) begin
      a = operand_t'($urandom);
      b = operand_t'($urandom);
      expAbs = (int'(a) >= int'(b)) ? int'(a) - int'(b) : int'(b) - int'(a);
      applyStimulus(1'b0, 1'b1, a, b);
      checkAll("random", expAbs, (int'(a) < int'(b)) ? 1 : 0, 1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_abs_diff

// File: doc/abs_diff.md
Name: abs_diff

Overview:
- Computes the unsigned absolute difference |data − Ref| of two WIDTH-bit operands.
- Result is registered, so the block drops into pipelined datapaths such as pixel/sample comparators and SAD accumulators.
- Single clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  qualifies data/Ref this cycle.
- data  input  WIDTH  unsigned operand A.
- Ref  input  WIDTH  unsigned reference operand B.
- result  output  WIDTH  registered |data − Ref|.
- data_lt_ref  output  1  registered flag, 1 when data < Ref (unsigned).
- out_valid  output  1  registered; result/data_lt_ref updated from a valid input.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: on a rising clk with rst=1, result=0, data_lt_ref=0 and out_valid=0. rst has priority over in_valid.
- Latency is 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- in_valid=1 at an edge:
  - result <= (data ≥ Ref) ? data − Ref : Ref − data.
  - data_lt_ref <= (data < Ref).
  - out_valid <= 1.
- in_valid=0 at an edge: result and data_lt_ref hold their previous values; out_valid <= 0.
- Arithmetic:
  - Operands are unsigned.
  - Compute D = data − Ref in WIDTH+1 bits; the borrow (MSB) is data_lt_ref.
  - If borrow=1, result = two's complement of D[WIDTH-1:0]; else result = D[WIDTH-1:0].
  - The result always fits in WIDTH bits; max is 2^WIDTH − 1 (0 vs all-ones). No saturation or overflow is possible.
- Equal operands: result=0, data_lt_ref=0.
- Symmetry: swapping data and Ref gives the same result; the flag inverts except when the operands are equal.
- No handshake backpressure: a new valid input is accepted every cycle, full throughput.
- Reset asserted mid-stream: the next edge clears all outputs and discards the in-flight operation. The first valid input after rst deasserts produces output one cycle later.
- No X propagation from an idle bus: with in_valid=0, result must not change even if data/Ref are X.

Decomposition:
- Shared package abs_diff_pkg:
  - ABS_DIFF_WIDTH default constant (8).
  - Typedef operand_t = logic [ABS_DIFF_WIDTH-1:0].
- One natural sub-module: abs_diff_sub, a WIDTH-bit ripple-borrow subtractor (generate loop of full subtractors) that outputs difference and borrow.
  - The top instantiates it once for data − Ref.
  - The top adds the conditional two's-complement negate (XOR with borrow, plus borrow) and the output registers.

Test Plan:
- Reset then basic: rst 2 cycles, then data=0x2E, Ref=0x0E, in_valid=1 -> next cycle result=0x20, data_lt_ref=0, out_valid=1.
- Small deltas: data=0x2E, Ref=0x0F -> 0x1F. Then data=0x2F, Ref=0x0F -> 0x20.
- data<Ref: data=0x2F, Ref=0x8F -> result=0x60, data_lt_ref=1. Swapped operands -> 0x60, data_lt_ref=0.
- Boundaries:
  - data=0x00, Ref=0xFF -> 0xFF, flag=1.
  - data=0xFF, Ref=0x00 -> 0xFF, flag=0.
  - data=Ref=0xA5 -> 0x00, flag=0.
- Hold/throughput: valid inputs back-to-back each cycle produce one result per cycle. Then in_valid=0 with random data -> result holds the last value, out_valid=0.
- Reset mid-stream, plus randomized check:
  - Assert rst while in_valid=1 -> next edge result=0, out_valid=0.
  - Then 1000 random {data,Ref} pairs checked against the reference model |a−b| with 1-cycle delay.
